// File: rtl/rtc_pkg.sv
// Shared encodings, BCD limits and helpers
// for the BCD real-time clock with alarms.
package rtc_pkg;

  localparam logic [2:0] SEL_SEC  = 3'd0;
  localparam logic [2:0] SEL_MIN  = 3'd1;
  localparam logic [2:0] SEL_HR   = 3'd2;
  localparam logic [2:0] SEL_WEEK = 3'd3;
  localparam logic [2:0] SEL_AHR  = 3'd4;
  localparam logic [2:0] SEL_AMIN = 3'd5;

  localparam logic [7:0] BCD_MIN_MAX  = 8'h59;
  localparam logic [7:0] BCD_HR_MAX   = 8'h23;
  localparam logic [7:0] BCD_WEEK_MAX = 8'h06;

  typedef enum logic {
    WR_IDLE,
    WR_APPLY
  } wr_st_t;

  function automatic logic bcd_ok(
    input logic [7:0] d,
    input logic [7:0] mx
  );
    return (d[7:4] <= 4'd9) &&
           (d[3:0] <= 4'd9) &&
           (d <= mx);
  endfunction

  // Returns {pm, bcd_hour} for the 12-hour view.
  function automatic logic [8:0] hr_12(
    input logic [7:0] h
  );
    logic [4:0] b;
    logic [4:0] t;
    logic [3:0] ones;
    logic       tens;
    b = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
    if (b == 5'd0)
      t = 5'd12;
    else if (b > 5'd12)
      t = b - 5'd12;
    else
      t = b;
    tens = (t >= 5'd10);
    ones = tens ? 4'(t - 5'd10) : t[3:0];
    return {(b >= 5'd12), 3'd0, tens, ones};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX,
// with load priority and carry out.
module bcd_mod_counter
  import rtc_pkg::*;
#(
  parameter logic [7:0] MAX = BCD_MIN_MAX
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       en,
  input  logic       ld,
  input  logic [7:0] ld_data,
  output logic [7:0] q,
  output logic [7:0] nxt,
  output logic       co
);

  logic [7:0] inc;

  always_comb begin
    inc = (q[3:0] == 4'd9) ?
          {q[7:4] + 4'd1, 4'd0} :
          {q[7:4], q[3:0] + 4'd1};
    co  = en & ~ld & (q == MAX);
    nxt = q;
    if (ld)
      nxt = ld_data;
    else if (en)
      nxt = (q == MAX) ? 8'h00 : inc;
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst)
      q <= 8'h00;
    else
      q <= nxt;
  end

endmodule

// File: rtl/rtc_bcd_alarm.sv
// BCD time-of-day clock with weekday,
// write port, alarms and hourly chime.
module rtc_bcd_alarm
  import rtc_pkg::*;
#(
  parameter int CLK_HZ   = 40000000,
  parameter int N_ALARM  = 2,
  parameter int CHIME_HZ = 500,
  localparam int IW =
    (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic               CLOCK,
  input  logic               rst,
  input  logic               set_valid,
  output logic               set_ready,
  input  logic [2:0]         set_sel,
  input  logic [IW-1:0]      set_idx,
  input  logic [7:0]         set_data,
  output logic               set_err,
  input  logic               mode12,
  input  logic [N_ALARM-1:0] alarm_en,
  input  logic [N_ALARM-1:0] alarm_clr,
  output logic [7:0]         sec,
  output logic [7:0]         min,
  output logic [7:0]         hr,
  output logic               pm,
  output logic [2:0]         week,
  output logic               tick,
  output logic [N_ALARM-1:0] alarm_hit,
  output logic               chime
);

  localparam int PW =
    (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int CDIV0 =
    CLK_HZ / (2 * CHIME_HZ);
  localparam int CDIV =
    (CDIV0 > 0) ? CDIV0 : 1;
  localparam int CFST =
    (CDIV / 2 > 0) ? CDIV / 2 : 1;

  wr_st_t        st;
  logic [2:0]    c_sel;
  logic [IW-1:0] c_idx;
  logic [7:0]    c_data;
  logic          c_ok;
  logic          in_ok;
  logic          wr;

  logic [PW-1:0] psc;
  logic [7:0]    sec_q, min_q, hr_q;
  logic [7:0]    sec_n, min_n, hr_n;
  logic          sec_co, min_co, hr_co;
  logic [2:0]    wk;
  logic [31:0]   ccnt;
  logic          chm;
  logic          act, fst;
  logic [8:0]    h12;

  assign wr   = (st == WR_APPLY) & c_ok;
  assign tick = (psc == PW'(CLK_HZ - 1));

  always_comb begin
    in_ok = 1'b0;
    unique case (1'b1)
      (set_sel == SEL_SEC),
      (set_sel == SEL_MIN):
        in_ok = bcd_ok(set_data, BCD_MIN_MAX);
      (set_sel == SEL_HR):
        in_ok = bcd_ok(set_data, BCD_HR_MAX);
      (set_sel == SEL_WEEK):
        in_ok = bcd_ok(set_data, BCD_WEEK_MAX);
      (set_sel == SEL_AHR):
        in_ok = bcd_ok(set_data, BCD_HR_MAX) &&
                (32'(set_idx) < 32'(N_ALARM));
      (set_sel == SEL_AMIN):
        in_ok = bcd_ok(set_data, BCD_MIN_MAX) &&
                (32'(set_idx) < 32'(N_ALARM));
      default:
        in_ok = 1'b0;
    endcase
  end

  // Validity is judged at capture so set_err
  // can be a register that lines up with APPLY.
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      st        <= WR_IDLE;
      set_ready <= 1'b1;
      set_err   <= 1'b0;
      c_sel     <= 3'd0;
      c_idx     <= '0;
      c_data    <= 8'h00;
      c_ok      <= 1'b0;
    end else begin
      unique case (st)
        WR_IDLE: begin
          if (set_valid && set_ready) begin
            st        <= WR_APPLY;
            set_ready <= 1'b0;
            set_err   <= ~in_ok;
            c_sel     <= set_sel;
            c_idx     <= set_idx;
            c_data    <= set_data;
            c_ok      <= in_ok;
          end
        end
        WR_APPLY: begin
          st        <= WR_IDLE;
          set_ready <= 1'b1;
          set_err   <= 1'b0;
          c_ok      <= 1'b0;
        end
        default: st <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst)
      psc <= '0;
    else if ((wr && c_sel == SEL_SEC) || tick)
      psc <= '0;
    else
      psc <= psc + 1'b1;
  end

  bcd_mod_counter #(.MAX(BCD_MIN_MAX)) u_sec (
    .CLOCK   (CLOCK),
    .rst     (rst),
    .en      (tick),
    .ld      (wr && c_sel == SEL_SEC),
    .ld_data (c_data),
    .q       (sec_q),
    .nxt     (sec_n),
    .co      (sec_co)
  );

  bcd_mod_counter #(.MAX(BCD_MIN_MAX)) u_min (
    .CLOCK   (CLOCK),
    .rst     (rst),
    .en      (sec_co),
    .ld      (wr && c_sel == SEL_MIN),
    .ld_data (c_data),
    .q       (min_q),
    .nxt     (min_n),
    .co      (min_co)
  );

  bcd_mod_counter #(.MAX(BCD_HR_MAX)) u_hr (
    .CLOCK   (CLOCK),
    .rst     (rst),
    .en      (min_co),
    .ld      (wr && c_sel == SEL_HR),
    .ld_data (c_data),
    .q       (hr_q),
    .nxt     (hr_n),
    .co      (hr_co)
  );

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst)
      wk <= 3'd0;
    else if (wr && c_sel == SEL_WEEK)
      wk <= c_data[2:0];
    else if (hr_co)
      wk <= (wk == BCD_WEEK_MAX[2:0]) ?
            3'd0 : wk + 3'd1;
  end

  for (genvar k = 0; k < N_ALARM; k++) begin : g_al
    logic [7:0] a_hr, a_min;
    logic       hk, match;
    logic       sel_k;

    assign sel_k = (32'(c_idx) == k);
    // Compare against the time this tick produces.
    assign match = alarm_en[k] && tick &&
                   (sec_n == 8'h00) &&
                   (hr_n == a_hr) &&
                   (min_n == a_min);

    always_ff @(posedge CLOCK or posedge rst) begin
      if (rst) begin
        a_hr  <= 8'h00;
        a_min <= 8'h00;
        hk    <= 1'b0;
      end else begin
        if (wr && sel_k && c_sel == SEL_AHR)
          a_hr <= c_data;
        if (wr && sel_k && c_sel == SEL_AMIN)
          a_min <= c_data;
        hk <= match | (hk & ~alarm_clr[k]);
      end
    end

    assign alarm_hit[k] = hk;
  end

  assign fst = (min_q == BCD_MIN_MAX) &&
               (sec_q == 8'h59);
  assign act = (min_q == BCD_MIN_MAX) &&
               (sec_q >= 8'h55) &&
               (sec_q <= 8'h59);

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      ccnt <= 32'd0;
      chm  <= 1'b0;
    end else if (!act) begin
      ccnt <= 32'd0;
      chm  <= 1'b0;
    end else if (ccnt >= (fst ? 32'(CFST - 1)
                              : 32'(CDIV - 1))) begin
      ccnt <= 32'd0;
      chm  <= ~chm;
    end else begin
      ccnt <= ccnt + 32'd1;
    end
  end

  assign h12   = hr_12(hr_q);
  assign sec   = sec_q;
  assign min   = min_q;
  assign hr    = mode12 ? h12[7:0] : hr_q;
  assign pm    = mode12 & h12[8];
  assign week  = wk;
  assign chime = chm;

endmodule

// File: tb/tb_rtc_bcd_alarm.sv
// Directed bench for rtc_bcd_alarm with
// CLK_HZ=10 and CHIME_HZ=1.
module tb_rtc_bcd_alarm;

  logic       CLOCK = 1'b0;
  logic       rst;
  logic       set_valid;
  logic       set_ready;
  logic [2:0] set_sel;
  logic [0:0] set_idx;
  logic [7:0] set_data;
  logic       set_err;
  logic       mode12;
  logic [1:0] alarm_en;
  logic [1:0] alarm_clr;
  logic [7:0] sec, min, hr;
  logic       pm;
  logic [2:0] week;
  logic       tick;
  logic [1:0] alarm_hit;
  logic       chime;

  int n_chk  = 0;
  int n_fail = 0;

  rtc_bcd_alarm #(
    .CLK_HZ   (10),
    .N_ALARM  (2),
    .CHIME_HZ (1)
  ) dut (
    .CLOCK     (CLOCK),
    .rst       (rst),
    .set_valid (set_valid),
    .set_ready (set_ready),
    .set_sel   (set_sel),
    .set_idx   (set_idx),
    .set_data  (set_data),
    .set_err   (set_err),
    .mode12    (mode12),
    .alarm_en  (alarm_en),
    .alarm_clr (alarm_clr),
    .sec       (sec),
    .min       (min),
    .hr        (hr),
    .pm        (pm),
    .week      (week),
    .tick      (tick),
    .alarm_hit (alarm_hit),
    .chime     (chime)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the
  // negedge after the APPLY cycle.
  task automatic wr(
    input  logic [2:0] s,
    input  logic       i,
    input  logic [7:0] d,
    output logic       err,
    output logic       rdy_a,
    output logic       rdy_b
  );
    set_sel   = s;
    set_idx   = i;
    set_data  = d;
    set_valid = 1'b1;
    @(negedge CLOCK);
    set_valid = 1'b0;
    err   = set_err;
    rdy_a = set_ready;
    @(negedge CLOCK);
    rdy_b = set_ready;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e, ra, rb;
    int   first, second;
    int   tog[16];
    int   n_tog;
    logic prev;
    logic found;

    rst       = 1'b1;
    set_valid = 1'b0;
    set_sel   = 3'd0;
    set_idx   = 1'b0;
    set_data  = 8'h00;
    mode12    = 1'b0;
    alarm_en  = 2'b00;
    alarm_clr = 2'b00;
    first     = -1;
    second    = -1;
    n_tog     = 0;
    for (int i = 0; i < 16; i++) tog[i] = 0;

    repeat (3) @(negedge CLOCK);
    chk("rst_time", {8'h0, hr, min, sec}, 32'h0);
    chk("rst_week", 32'(week), 32'd0);
    chk("rst_ready", 32'(set_ready), 32'd1);
    chk("rst_err", 32'(set_err), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_hit", 32'(alarm_hit), 32'd0);
    chk("rst_chime", 32'(chime), 32'd0);

    rst = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge CLOCK);
      if (tick) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    chk("tick_first", 32'(first), 32'd9);
    chk("tick_period", 32'(second - first), 32'd10);
    chk("60tick_sec", 32'(sec), 32'h00);
    chk("60tick_min", 32'(min), 32'h01);

    wr(3'd2, 1'b0, 8'h23, e, ra, rb);
    wr(3'd1, 1'b0, 8'h59, e, ra, rb);
    wr(3'd3, 1'b0, 8'h06, e, ra, rb);
    wr(3'd0, 1'b0, 8'h59, e, ra, rb);
    chk("load_time", {8'h0, hr, min, sec},
        32'h00235959);
    chk("load_week", 32'(week), 32'd6);
    repeat (10) @(negedge CLOCK);
    chk("wrap_time", {8'h0, hr, min, sec}, 32'h0);
    chk("wrap_week", 32'(week), 32'd0);

    wr(3'd0, 1'b0, 8'h5A, e, ra, rb);
    chk("bad_sec_err", 32'(e), 32'd1);
    chk("bad_sec_rdy_apply", 32'(ra), 32'd0);
    chk("bad_sec_rdy_after", 32'(rb), 32'd1);
    chk("bad_sec_keep", 32'(sec), 32'h00);
    wr(3'd2, 1'b0, 8'h24, e, ra, rb);
    chk("bad_hr_err", 32'(e), 32'd1);
    wr(3'd6, 1'b0, 8'h00, e, ra, rb);
    chk("rsvd_err", 32'(e), 32'd1);
    wr(3'd3, 1'b0, 8'h07, e, ra, rb);
    chk("bad_week_err", 32'(e), 32'd1);
    chk("bad_week_keep", 32'(week), 32'd0);
    chk("bad_hr_keep", 32'(hr), 32'h00);

    mode12 = 1'b1;
    wr(3'd2, 1'b0, 8'h00, e, ra, rb);
    chk("good_wr_err", 32'(e), 32'd0);
    chk("m12_00", {23'h0, pm, hr}, 32'h012);
    wr(3'd2, 1'b0, 8'h12, e, ra, rb);
    chk("m12_12", {23'h0, pm, hr}, 32'h112);
    wr(3'd2, 1'b0, 8'h13, e, ra, rb);
    chk("m12_13", {23'h0, pm, hr}, 32'h101);
    wr(3'd2, 1'b0, 8'h23, e, ra, rb);
    chk("m12_23", {23'h0, pm, hr}, 32'h111);
    mode12 = 1'b0;
    @(negedge CLOCK);
    chk("m24_23", {23'h0, pm, hr}, 32'h023);

    alarm_en = 2'b01;
    wr(3'd4, 1'b0, 8'h07, e, ra, rb);
    wr(3'd5, 1'b0, 8'h30, e, ra, rb);
    wr(3'd4, 1'b1, 8'h07, e, ra, rb);
    wr(3'd5, 1'b1, 8'h30, e, ra, rb);
    wr(3'd2, 1'b0, 8'h07, e, ra, rb);
    wr(3'd1, 1'b0, 8'h29, e, ra, rb);
    wr(3'd0, 1'b0, 8'h59, e, ra, rb);
    chk("alm_pre", 32'(alarm_hit), 32'd0);
    repeat (10) @(negedge CLOCK);
    chk("alm_time", {8'h0, hr, min, sec},
        32'h00073000);
    chk("alm_hit", 32'(alarm_hit), 32'b01);
    repeat (10) @(negedge CLOCK);
    chk("alm_sticky", 32'(alarm_hit), 32'b01);
    alarm_clr = 2'b01;
    @(negedge CLOCK);
    alarm_clr = 2'b00;
    chk("alm_clr", 32'(alarm_hit), 32'd0);

    wr(3'd1, 1'b0, 8'h59, e, ra, rb);
    wr(3'd0, 1'b0, 8'h54, e, ra, rb);
    chk("chm_54_sec", 32'(sec), 32'h54);
    chk("chm_54", 32'(chime), 32'd0);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge CLOCK);
      if (sec == 8'h55) found = 1'b1;
    end
    chk("chm_reach55", 32'(found), 32'd1);
    chk("chm_t0", 32'(chime), 32'd0);
    prev = chime;
    for (int t = 1; t <= 50; t++) begin
      @(negedge CLOCK);
      if (chime !== prev) begin
        if (n_tog < 16) tog[n_tog] = t;
        n_tog++;
      end
      prev = chime;
    end
    chk("chm_ntog", 32'(n_tog), 32'd13);
    chk("chm_first", 32'(tog[0]), 32'd5);
    chk("chm_slow", 32'(tog[1] - tog[0]), 32'd5);
    chk("chm_to59", 32'(tog[8]), 32'd42);
    chk("chm_fast", 32'(tog[12] - tog[11]), 32'd2);
    repeat (2) @(negedge CLOCK);
    chk("chm_00", 32'(chime), 32'd0);
    chk("chm_hr", {16'h0, hr, min}, 32'h0800);

    set_sel   = 3'd2;
    set_data  = 8'h05;
    set_valid = 1'b1;
    @(negedge CLOCK);
    set_valid = 1'b0;
    rst = 1'b1;
    @(negedge CLOCK);
    chk("rst_apply_hr", 32'(hr), 32'h00);
    chk("rst_apply_rdy", 32'(set_ready), 32'd1);
    chk("rst_apply_err", 32'(set_err), 32'd0);
    rst = 1'b0;
    @(negedge CLOCK);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
